// File: rtl/net_node_n_if.sv
//------------------------------------------------------------------------------
// net_node_n_if : driver-slot bus and resolved-net outputs of one NMOS net node
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface net_node_n_if #(
    parameter int N = 2
);
    localparam int W = 2;

    logic [N*W-1:0] i;
    logic [W-1:0]   out;
    logic           floating;
    logic           fight;
    logic           stable;
    logic           err;

    modport master (output i, input out, floating, fight, stable, err);
    modport slave  (input i, output out, floating, fight, stable, err);
endinterface

`default_nettype wire

// File: rtl/net_node_n.sv
//------------------------------------------------------------------------------
// net_node_n : sequential resolver for one electrical net (pull-down dominant,
//              charge retention, settle/contention status).
// Optional   : NODE_DECAY_EN enables leakage of held charge to logic 0.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module net_node_n #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int DECAY_CYCLES  = 16
) (
    input  wire logic     eclk,
    input  wire logic     erst,
    net_node_n_if.slave   bus
);
    localparam int         c_W         = 2;
    localparam logic [1:0] c_LO        = 2'b01;
    localparam logic [1:0] c_HI        = 2'b10;
    localparam logic [1:0] c_DRV_LO    = 2'd0;
    localparam logic [1:0] c_DRV_HI    = 2'd1;
    localparam logic [1:0] c_FLOAT     = 2'd2;
    localparam logic [7:0] c_STABLE_TH = 8'(STABLE_CYCLES);

    if (N < 1 || STABLE_CYCLES < 1 || STABLE_CYCLES > 255 ||
        DECAY_CYCLES < 1 || DECAY_CYCLES > 65535) begin : g_param_chk
        $error("net_node_n: parameter out of range");
    end

    logic [N-1:0] w_slot_lo;
    logic [N-1:0] w_slot_hi;
    logic [N-1:0] w_slot_ill;

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign w_slot_lo[k]  = (bus.i[k*c_W +: c_W] == 2'b01);
        assign w_slot_hi[k]  = (bus.i[k*c_W +: c_W] == 2'b10);
        assign w_slot_ill[k] = (bus.i[k*c_W +: c_W] == 2'b11);
    end

    logic w_lo;
    logic w_hi;
    logic w_ill;
    assign w_lo  = |w_slot_lo;
    assign w_hi  = |w_slot_hi;
    assign w_ill = |w_slot_ill;

    logic [1:0] r_out;
    logic [1:0] r_state;
    logic       r_fight;
    logic [7:0] r_cnt;
    logic       r_stable;
    logic       r_err;
    logic       w_decay_fire;

`ifdef NODE_DECAY_EN
    localparam logic [15:0] c_DECAY_TH = 16'(DECAY_CYCLES);
    logic [15:0] r_decay;
    logic [15:0] w_decay_nxt;

    // Counts undriven edges; the edge that reaches the threshold leaks a held 1.
    always_comb begin
        w_decay_nxt  = r_decay;
        w_decay_fire = 1'b0;
        if (w_lo || w_hi) begin
            w_decay_nxt = '0;
        end else if (r_decay != c_DECAY_TH) begin
            w_decay_nxt  = r_decay + 16'd1;
            w_decay_fire = (w_decay_nxt == c_DECAY_TH) && (r_out == c_HI);
        end
    end

    always_ff @(posedge eclk) begin
        if (!erst) begin
            r_decay <= '0;
        end else begin
            r_decay <= w_decay_nxt;
        end
    end
`else
    assign w_decay_fire = 1'b0;
`endif

    logic [1:0] w_next_out;
    logic [7:0] w_cnt_nxt;

    always_comb begin
        w_next_out = r_out;
        if (w_lo) begin
            w_next_out = c_LO;
        end else if (w_hi) begin
            w_next_out = c_HI;
        end else if (w_decay_fire) begin
            w_next_out = c_LO;
        end
        w_cnt_nxt = r_cnt;
        if (w_next_out != r_out) begin
            w_cnt_nxt = 8'd0;
        end else if (r_cnt != 8'hFF) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end
    end

    always_ff @(posedge eclk) begin
        if (!erst) begin
            r_out    <= c_LO;
            r_state  <= c_FLOAT;
            r_fight  <= 1'b0;
            r_cnt    <= 8'd0;
            r_stable <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_out    <= w_next_out;
            r_fight  <= w_lo && w_hi;
            r_cnt    <= w_cnt_nxt;
            r_stable <= (w_cnt_nxt >= c_STABLE_TH);
            r_err    <= r_err | w_ill;
            if (w_lo) begin
                r_state <= c_DRV_LO;
            end else if (w_hi) begin
                r_state <= c_DRV_HI;
            end else begin
                r_state <= c_FLOAT;
            end
        end
    end

    assign bus.out      = r_out;
    assign bus.floating = (r_state == c_FLOAT);
    assign bus.fight    = r_fight;
    assign bus.stable   = r_stable;
    assign bus.err      = r_err;

endmodule

`default_nettype wire
